// File: rtl/sprite_pkg.sv
// Shared sprite types, palette constants and the palette lookup.
// Used by the base renderer and reusable by other sprite renderers.
package sprite_pkg;

  localparam logic [23:0] LIVE_GREY     = 24'hB0B0B0;
  localparam logic [23:0] LIVE_DARK     = 24'h404040;
  localparam logic [23:0] DEAD_GREY     = 24'h585858;
  localparam logic [23:0] DEAD_DARK     = 24'h202020;
  localparam logic [23:0] DEBUG_MAGENTA = 24'hFF00FF;

  typedef enum logic [1:0] {
    ALIVE     = 2'd0,
    FLASH     = 2'd1,
    DESTROYED = 2'd2
  } base_state_t;

  // 16x16 texels, 5 bits stored per texel; only [3:0] is a colour index.
  typedef logic [0:15][0:15][4:0] sprite16_t;

  // Resolve a colour index.
  // Index 0 is transparent and maps to black.
  // The dead variant swaps in the darker greys.
  function automatic logic [23:0] palette_lookup(input logic [3:0] idx,
                                                 input logic       dead);
    logic [23:0] rgb;
    case (idx)
      4'd0:    rgb = 24'h000000;
      4'd1:    rgb = dead ? DEAD_GREY : LIVE_GREY;
      4'd2:    rgb = dead ? DEAD_DARK : LIVE_DARK;
      default: rgb = DEBUG_MAGENTA;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/sprite_hit_test.sv
// Combinational box test for a 16x16 sprite.
// The sprite is scaled by 2^SCALE_SHIFT.
// Offsets wrap modulo 1024, so a scan position left of or above the box
// wraps to a large offset and falls outside.
module sprite_hit_test #(
  parameter int SCALE_SHIFT = 1
) (
  input  logic [9:0] draw_x_i,
  input  logic [9:0] draw_y_i,
  input  logic [9:0] base_x_i,
  input  logic [9:0] base_y_i,
  output logic       inside_o,
  output logic [3:0] row_o,
  output logic [3:0] col_o
);

  localparam logic [9:0] SIZE = 10'(16 << SCALE_SHIFT);

  logic [9:0] dx;
  logic [9:0] dy;

  // Offsets, box test and texel coordinates.
  always_comb begin
    dx       = draw_x_i - base_x_i;
    dy       = draw_y_i - base_y_i;
    inside_o = (dx < SIZE) && (dy < SIZE);
    col_o    = 4'(dx >> SCALE_SHIFT);
    row_o    = 4'(dy >> SCALE_SHIFT);
  end

endmodule

// File: rtl/base_sprite_renderer.sv
// Renders the player's base (eagle) for the pixel pipeline.
// It also runs the ALIVE / FLASH / DESTROYED hit animation.
//
// Handshake: there is no backpressure.
// - in_valid qualifies DrawX/DrawY for exactly one cycle.
// - pix_valid qualifies pix_opaque/pix_rgb two cycles later.
// - Every accepted pixel is produced; throughput is one pixel per cycle.
module base_sprite_renderer
  import sprite_pkg::*;
#(
  parameter int SCALE_SHIFT  = 1,
  parameter int FLASH_FRAMES = 32,
  parameter int BLINK_BIT    = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  sprite16_t   sprite,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        in_valid,
  input  logic [9:0]  BaseX,
  input  logic [9:0]  BaseY,
  input  logic        frame_start,
  input  logic        hit,
  input  logic        restart,
  output logic        pix_valid,
  output logic        pix_opaque,
  output logic [23:0] pix_rgb,
  output logic        destroyed,
  output base_state_t dbg_state_o
);

  localparam int CNT_W = $clog2(FLASH_FRAMES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLASH_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // FSM and frame counter.
  base_state_t      state_q, state_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  // Stage 1: box test and texel coordinates.
  logic       s1_valid_q, s1_inside_q;
  logic [3:0] s1_row_q, s1_col_q;
  logic       hit_inside;
  logic [3:0] hit_row, hit_col;

  // Stage 2: palette output.
  logic        s2_valid_q, s2_opaque_q;
  logic [23:0] s2_rgb_q;
  logic        s2_opaque_d;
  logic [23:0] s2_rgb_d;
  logic [3:0]  idx;
  logic        visible;

  sprite_hit_test #(.SCALE_SHIFT(SCALE_SHIFT)) u_hit_test (
    .draw_x_i (DrawX),
    .draw_y_i (DrawY),
    .base_x_i (BaseX),
    .base_y_i (BaseY),
    .inside_o (hit_inside),
    .row_o    (hit_row),
    .col_o    (hit_col)
  );

  // Animation next state.
  // restart wins over everything; hit only matters while ALIVE.
  // The counter saturates instead of wrapping.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    if (restart) begin
      state_d     = ALIVE;
      frame_cnt_d = '0;
    end else begin
      case (state_q)
        ALIVE: begin
          if (hit) begin
            state_d     = FLASH;
            frame_cnt_d = '0;
          end
        end
        FLASH: begin
          if (frame_start) begin
            if (frame_cnt_q == CNT_LAST) state_d = DESTROYED;
            if (frame_cnt_q != CNT_MAX)  frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
        DESTROYED: begin
          if (frame_start && frame_cnt_q != CNT_MAX)
            frame_cnt_d = frame_cnt_q + 1'b1;
        end
        default: begin
          state_d     = ALIVE;
          frame_cnt_d = '0;
        end
      endcase
    end
  end

  // Animation state register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ALIVE;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Stage 1 pipeline register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_valid_q  <= 1'b0;
      s1_inside_q <= 1'b0;
      s1_row_q    <= '0;
      s1_col_q    <= '0;
    end else begin
      s1_valid_q  <= in_valid;
      s1_inside_q <= hit_inside;
      s1_row_q    <= hit_row;
      s1_col_q    <= hit_col;
    end
  end

  // Texel fetch, blink gating and palette.
  // Uses the current animation state.
  always_comb begin
    idx         = sprite[s1_row_q][s1_col_q][3:0];
    visible     = !((state_q == FLASH) && frame_cnt_q[BLINK_BIT]);
    s2_opaque_d = s1_valid_q && s1_inside_q && (idx != 4'd0) && visible;
    s2_rgb_d    = s2_opaque_d ? palette_lookup(idx, state_q == DESTROYED)
                              : 24'h000000;
  end

  // Stage 2 pipeline register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s2_valid_q  <= 1'b0;
      s2_opaque_q <= 1'b0;
      s2_rgb_q    <= '0;
    end else begin
      s2_valid_q  <= s1_valid_q;
      s2_opaque_q <= s2_opaque_d;
      s2_rgb_q    <= s2_rgb_d;
    end
  end

  assign pix_valid   = s2_valid_q;
  assign pix_opaque  = s2_opaque_q;
  assign pix_rgb     = s2_rgb_q;
  assign destroyed   = (state_q == DESTROYED);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_base_sprite_renderer.sv
// Directed bench for base_sprite_renderer with hand-computed expectations.
module tb_base_sprite_renderer;
  import sprite_pkg::*;

  logic        Clk;
  logic        Reset;
  sprite16_t   sprite;
  logic [9:0]  DrawX, DrawY, BaseX, BaseY;
  logic        in_valid, frame_start, hit, restart;
  logic        pix_valid, pix_opaque, destroyed;
  logic [23:0] pix_rgb;
  base_state_t dbg_state_o;

  int checks   = 0;
  int failures = 0;
  logic [24:0] exp_q[$];

  base_sprite_renderer dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .sprite      (sprite),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .in_valid    (in_valid),
    .BaseX       (BaseX),
    .BaseY       (BaseY),
    .frame_start (frame_start),
    .hit         (hit),
    .restart     (restart),
    .pix_valid   (pix_valid),
    .pix_opaque  (pix_opaque),
    .pix_rgb     (pix_rgb),
    .destroyed   (destroyed),
    .dbg_state_o (dbg_state_o)
  );

  // Clock.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Send one pixel; check its output two edges later.
  task automatic probe(input int x, input int y, input logic exp_op,
                       input logic [23:0] exp_rgb, input string tag);
    @(posedge Clk); #1;
    DrawX = 10'(x); DrawY = 10'(y); in_valid = 1'b1;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    @(posedge Clk); #1;
    check({tag, "_valid"}, 32'(pix_valid), 32'd1);
    check({tag, "_opaque"}, 32'(pix_opaque), 32'(exp_op));
    check({tag, "_rgb"}, 32'(pix_rgb), 32'(exp_rgb));
  endtask

  // One-cycle pulse on any combination of hit / frame_start / restart.
  task automatic pulse(input logic h, input logic f, input logic r);
    @(posedge Clk); #1;
    hit = h; frame_start = f; restart = r;
    @(posedge Clk); #1;
    hit = 1'b0; frame_start = 1'b0; restart = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) pulse(1'b0, 1'b1, 1'b0);
  endtask

  // Expected {opaque, rgb} on scan line y = 416 with the base at (192, 416), ALIVE.
  function automatic logic [24:0] exp_row0(input int x);
    int dx;
    logic [4:0] t;
    dx = x - 192;
    if (dx < 0 || dx > 31) return 25'd0;
    t = sprite[0][dx / 2];
    case (t[3:0])
      4'd0:    return 25'd0;
      4'd1:    return {1'b1, 24'hB0B0B0};
      4'd2:    return {1'b1, 24'h404040};
      default: return {1'b1, 24'hFF00FF};
    endcase
  endfunction

  initial begin
    logic [24:0] exp;
    Reset = 1'b1; in_valid = 1'b0; DrawX = '0; DrawY = '0;
    BaseX = 10'd192; BaseY = 10'd416;
    hit = 1'b0; frame_start = 1'b0; restart = 1'b0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) sprite[r][c] = 5'd1;
    sprite[0][0]  = 5'd0;
    sprite[0][1]  = 5'h11;  // bit 4 is not part of the index
    sprite[0][2]  = 5'd2;
    sprite[0][3]  = 5'd7;
    sprite[15][1] = 5'd2;

    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    check("rst_valid", 32'(pix_valid), 32'd0);
    check("rst_opaque", 32'(pix_opaque), 32'd0);
    check("rst_rgb", 32'(pix_rgb), 32'd0);
    check("rst_destroyed", 32'(destroyed), 32'd0);
    check("rst_state", 32'(dbg_state_o), 32'(ALIVE));

    // Stream scan line 416 across the box edges; results arrive two cycles later.
    for (int i = 0; i < 42; i++) begin
      @(posedge Clk); #1;
      if (i >= 2) begin
        exp = exp_q.pop_front();
        check("stream_valid", 32'(pix_valid), 32'd1);
        check("stream_pix", {7'd0, pix_opaque, pix_rgb}, {7'd0, exp});
      end
      if (i < 40) begin
        DrawX = 10'(188 + i); DrawY = 10'd416; in_valid = 1'b1;
        exp_q.push_back(exp_row0(188 + i));
      end else begin
        in_valid = 1'b0;
      end
    end

    // Directed render points.
    probe(194, 416, 1'b1, 24'hB0B0B0, "alive_idx1");
    probe(192, 416, 1'b0, 24'h000000, "alive_idx0");
    probe(224, 416, 1'b0, 24'h000000, "outside_x");
    probe(223, 416, 1'b1, 24'hB0B0B0, "last_col");
    probe(194, 447, 1'b1, 24'h404040, "last_row_idx2");
    probe(194, 448, 1'b0, 24'h000000, "outside_y");
    probe(194, 415, 1'b0, 24'h000000, "above_wrap");

    // Flash then destroyed.
    pulse(1'b1, 1'b0, 1'b0);
    check("flash_state", 32'(dbg_state_o), 32'(FLASH));
    probe(194, 416, 1'b1, 24'hB0B0B0, "flash_f0");
    frames(4);
    probe(194, 416, 1'b0, 24'h000000, "flash_f4");
    probe(198, 420, 1'b0, 24'h000000, "flash_f4b");
    frames(4);
    probe(194, 416, 1'b1, 24'hB0B0B0, "flash_f8");
    frames(23);
    check("f31_destroyed", 32'(destroyed), 32'd0);
    frames(1);
    check("f32_destroyed", 32'(destroyed), 32'd1);
    check("f32_state", 32'(dbg_state_o), 32'(DESTROYED));
    frames(40);
    check("dead_hold", 32'(destroyed), 32'd1);

    // Destroyed palette, ignored hit, restart.
    probe(194, 416, 1'b1, 24'h585858, "dead_idx1");
    probe(196, 416, 1'b1, 24'h202020, "dead_idx2");
    probe(198, 416, 1'b1, 24'hFF00FF, "dead_idx7");
    pulse(1'b1, 1'b0, 1'b0);
    check("dead_hit_ignored", 32'(dbg_state_o), 32'(DESTROYED));
    @(posedge Clk); #1;
    restart = 1'b1;
    check("restart_pre", 32'(destroyed), 32'd1);
    @(posedge Clk); #1;
    restart = 1'b0;
    check("restart_drop", 32'(destroyed), 32'd0);
    check("restart_state", 32'(dbg_state_o), 32'(ALIVE));
    probe(194, 416, 1'b1, 24'hB0B0B0, "restart_live");

    // hit + frame_start together: that frame is not counted.
    pulse(1'b1, 1'b1, 1'b0);
    check("hitfs_state", 32'(dbg_state_o), 32'(FLASH));
    frames(3);
    probe(194, 416, 1'b1, 24'hB0B0B0, "hitfs_f3");
    frames(1);
    probe(194, 416, 1'b0, 24'h000000, "hitfs_f4");
    pulse(1'b1, 1'b0, 1'b1);
    check("hitrst_flash", 32'(dbg_state_o), 32'(ALIVE));
    pulse(1'b1, 1'b0, 1'b1);
    check("hitrst_alive", 32'(dbg_state_o), 32'(ALIVE));
    probe(194, 416, 1'b1, 24'hB0B0B0, "hitrst_live");

    // Reset mid-line while DESTROYED and streaming inside the box.
    pulse(1'b1, 1'b0, 1'b0);
    frames(32);
    check("pre_rst_destroyed", 32'(destroyed), 32'd1);
    @(posedge Clk); #1;
    DrawX = 10'd194; DrawY = 10'd416; in_valid = 1'b1;
    repeat (2) @(posedge Clk);
    #1 check("pre_rst_rgb", 32'(pix_rgb), 32'h585858);
    #3 Reset = 1'b1;
    #1;
    check("arst_valid", 32'(pix_valid), 32'd0);
    check("arst_opaque", 32'(pix_opaque), 32'd0);
    check("arst_rgb", 32'(pix_rgb), 32'd0);
    check("arst_destroyed", 32'(destroyed), 32'd0);
    @(posedge Clk); #1;
    in_valid = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b0;
    check("arst_state", 32'(dbg_state_o), 32'(ALIVE));
    repeat (2) @(posedge Clk);
    #1 check("arst_idle", 32'(pix_valid), 32'd0);
    in_valid = 1'b1;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    check("arst_lat1", 32'(pix_valid), 32'd0);
    @(posedge Clk); #1;
    check("arst_lat2", 32'(pix_valid), 32'd1);
    check("arst_lat2_rgb", 32'(pix_rgb), 32'hB0B0B0);
    @(posedge Clk); #1;
    check("arst_lat3", 32'(pix_valid), 32'd0);

    // Edge and wrap with the base at the left screen edge.
    BaseX = 10'd0;
    probe(1023, 416, 1'b0, 24'h000000, "wrap_left");
    probe(0, 416, 1'b0, 24'h000000, "edge_idx0");
    probe(6, 416, 1'b1, 24'hFF00FF, "edge_idx7");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
